// File: rtl/free_list.sv
// rtl/free_list.sv - physical-register free list for the rename stage
// Circular buffer with speculative head, retire-time arch_head and push tail.
module free_list #(
   parameter int PHY_REGS     = 64,
   parameter int ARCH_REGS    = 32,
   parameter int WIDTH        = 2,
   parameter int RETIRE_WIDTH = 2,
   localparam int PHY_W       = $clog2(PHY_REGS),
   localparam int N           = PHY_REGS - ARCH_REGS,
   localparam int IDX_W       = $clog2(N),
   localparam int PTR_W       = IDX_W + 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [WIDTH-1:0]                     alloc_req_i,
   output logic                                 alloc_ready_o,
   output logic [WIDTH-1:0][PHY_W-1:0]          alloc_phy_o,
   input  logic [RETIRE_WIDTH-1:0]              retire_valid_i,
   input  logic [RETIRE_WIDTH-1:0]              retire_has_dst_i,
   input  logic [RETIRE_WIDTH-1:0][PHY_W-1:0]   retire_phy_old_i,
   input  logic                                 rewind_valid_i,
   output logic [PTR_W-1:0]                     free_count_o
);

   typedef logic [PHY_W-1:0] phy_reg_t;

   phy_reg_t                entries_q [N];
   logic [PTR_W-1:0]        head_q, head_d;
   logic [PTR_W-1:0]        arch_head_q, arch_head_d;
   logic [PTR_W-1:0]        tail_q, tail_d;
   logic [PTR_W-1:0]        count;
   logic [PTR_W-1:0]        alloc_cnt;
   logic [PTR_W-1:0]        ret_cnt;
   logic [PTR_W-1:0]        rd_ptr [WIDTH];
   logic [PTR_W-1:0]        wr_ptr [RETIRE_WIDTH];
   logic [RETIRE_WIDTH-1:0] wr_en;
   logic                    alloc_fire;

   // Wrap bit in the pointer MSB lets tail - head separate empty (0) from full (N).
   assign count         = tail_q - head_q;
   assign free_count_o  = count;
   assign alloc_ready_o = (count >= PTR_W'(WIDTH)) && !rewind_valid_i;
   assign alloc_fire    = alloc_ready_o && (|alloc_req_i);
   assign wr_en         = retire_valid_i & retire_has_dst_i;

   always_comb begin
      alloc_cnt = '0;
      for (int k = 0; k < WIDTH; k++) begin
         rd_ptr[k]      = head_q + alloc_cnt;
         alloc_phy_o[k] = entries_q[rd_ptr[k][IDX_W-1:0]];
         if (alloc_req_i[k]) alloc_cnt = alloc_cnt + PTR_W'(1);
      end
   end

   always_comb begin
      ret_cnt = '0;
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
         wr_ptr[j] = tail_q + ret_cnt;
         if (wr_en[j]) ret_cnt = ret_cnt + PTR_W'(1);
      end
      tail_d      = tail_q + ret_cnt;
      arch_head_d = arch_head_q + ret_cnt;
      head_d      = head_q;
      // Rewind lands on the post-retire arch_head so same-cycle retires stay committed.
      if (rewind_valid_i)  head_d = arch_head_d;
      else if (alloc_fire) head_d = head_q + alloc_cnt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N; i++) entries_q[i] <= phy_reg_t'(ARCH_REGS + i);
         head_q      <= '0;
         arch_head_q <= '0;
         tail_q      <= PTR_W'(N);
      end else begin
         for (int j = 0; j < RETIRE_WIDTH; j++) begin
            if (wr_en[j]) entries_q[wr_ptr[j][IDX_W-1:0]] <= retire_phy_old_i[j];
         end
         head_q      <= head_d;
         arch_head_q <= arch_head_d;
         tail_q      <= tail_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (count <= PTR_W'(N));
         assert (!alloc_fire || (alloc_cnt <= count));
         assert (PTR_W'(head_q - arch_head_q) <= PTR_W'(N));
      end
   end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - self-checking bench for free_list
// Reference model: free pool and in-flight allocations kept as ordered queues.
module tb_free_list;
   localparam int N = 32;

   logic            clock = 1'b0;
   logic            reset;
   logic [1:0]      req;
   logic            ready;
   logic [1:0][5:0] phy;
   logic [1:0]      rv, rh;
   logic [1:0][5:0] rp;
   logic            rw;
   logic [5:0]      fcnt;

   int n_cmp = 0;
   int n_err = 0;
   int free_q[$];
   int spec_q[$];

   free_list dut (
      .clock            (clock),
      .reset            (reset),
      .alloc_req_i      (req),
      .alloc_ready_o    (ready),
      .alloc_phy_o      (phy),
      .retire_valid_i   (rv),
      .retire_has_dst_i (rh),
      .retire_phy_old_i (rp),
      .rewind_valid_i   (rw),
      .free_count_o     (fcnt)
   );

   always #5 clock = ~clock;

   function automatic void model_step();
      if (reset) begin
         free_q.delete();
         spec_q.delete();
         for (int i = 0; i < N; i++) free_q.push_back(32 + i);
         return;
      end
      if (!rw && free_q.size() >= 2 && req != 2'b00)
         for (int k = 0; k < 2; k++)
            if (req[k]) spec_q.push_back(free_q.pop_front());
      for (int j = 0; j < 2; j++)
         if (rv[j] && rh[j]) begin
            void'(spec_q.pop_front());
            free_q.push_back(int'(rp[j]));
         end
      if (rw)
         while (spec_q.size() > 0) free_q.push_front(spec_q.pop_back());
   endfunction

   task automatic drive(input logic [1:0] r, input logic [1:0] v, input logic [1:0] h,
                        input logic [5:0] p1, input logic [5:0] p0, input logic w);
      req = r; rv = v; rh = h; rp[1] = p1; rp[0] = p0; rw = w;
      #1;
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic idle();
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      n_cmp++; if (fcnt !== 6'd32) begin n_err++; $display("FAIL reset_free_count: got %0d want 32", fcnt); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
      n_cmp++; if (phy[0] !== 6'd32) begin n_err++; $display("FAIL reset_lane0: got %0d want 32", phy[0]); end
      n_cmp++; if (phy[1] !== 6'd33) begin n_err++; $display("FAIL reset_lane1: got %0d want 33", phy[1]); end
      idle();
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int c = 0; c < 16; c++) begin
         drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
         n_cmp++; if (phy[0] !== 6'(32 + 2*c)) begin n_err++; $display("FAIL drain_lane0 c%0d: got %0d want %0d", c, phy[0], 32 + 2*c); end
         n_cmp++; if (phy[1] !== 6'(33 + 2*c)) begin n_err++; $display("FAIL drain_lane1 c%0d: got %0d want %0d", c, phy[1], 33 + 2*c); end
         n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL drain_ready c%0d: got %b want 1", c, ready); end
         step();
      end
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      n_cmp++; if (fcnt !== 6'd0) begin n_err++; $display("FAIL empty_count: got %0d want 0", fcnt); end
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL empty_ready: got %b want 0", ready); end
      step();
      idle();
      n_cmp++; if (fcnt !== 6'd0) begin n_err++; $display("FAIL empty_stall_count: got %0d want 0", fcnt); end
   endtask

   task automatic test_partial();
      do_reset();
      drive(2'b10, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      n_cmp++; if (phy[1] !== 6'd32) begin n_err++; $display("FAIL partial_lane1: got %0d want 32", phy[1]); end
      step();
      drive(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      n_cmp++; if (fcnt !== 6'd31) begin n_err++; $display("FAIL partial_count: got %0d want 31", fcnt); end
      n_cmp++; if (phy[0] !== 6'd33) begin n_err++; $display("FAIL partial_lane0: got %0d want 33", phy[0]); end
      step();
      idle();
      n_cmp++; if (fcnt !== 6'd30) begin n_err++; $display("FAIL partial_count2: got %0d want 30", fcnt); end
   endtask

   task automatic test_retire_refill();
      do_reset();
      for (int c = 0; c < 16; c++) begin
         drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
         step();
      end
      drive(2'b00, 2'b11, 2'b11, 6'd5, 6'd7, 1'b0);
      step();
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      n_cmp++; if (fcnt !== 6'd2) begin n_err++; $display("FAIL refill_count: got %0d want 2", fcnt); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL refill_ready: got %b want 1", ready); end
      n_cmp++; if (phy[0] !== 6'd7) begin n_err++; $display("FAIL refill_lane0: got %0d want 7", phy[0]); end
      n_cmp++; if (phy[1] !== 6'd5) begin n_err++; $display("FAIL refill_lane1: got %0d want 5", phy[1]); end
      step();
      idle();
      n_cmp++; if (fcnt !== 6'd0) begin n_err++; $display("FAIL refill_drained: got %0d want 0", fcnt); end
   endtask

   task automatic test_rewind();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
         step();
      end
      drive(2'b00, 2'b11, 2'b11, 6'd11, 6'd10, 1'b0);
      step();
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rewind_ready: got %b want 0", ready); end
      step();
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      n_cmp++; if (fcnt !== 6'd32) begin n_err++; $display("FAIL rewind_count: got %0d want 32", fcnt); end
      n_cmp++; if (phy[0] !== 6'd34) begin n_err++; $display("FAIL rewind_lane0: got %0d want 34", phy[0]); end
      n_cmp++; if (phy[1] !== 6'd35) begin n_err++; $display("FAIL rewind_lane1: got %0d want 35", phy[1]); end
      idle();
   endtask

   task automatic test_same_cycle();
      do_reset();
      for (int c = 0; c < 2; c++) begin
         drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
         step();
      end
      drive(2'b11, 2'b01, 2'b01, 6'd0, 6'd9, 1'b1);
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL same_ready: got %b want 0", ready); end
      step();
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      n_cmp++; if (fcnt !== 6'd32) begin n_err++; $display("FAIL same_count: got %0d want 32", fcnt); end
      n_cmp++; if (phy[0] !== 6'd33) begin n_err++; $display("FAIL same_lane0: got %0d want 33", phy[0]); end
      n_cmp++; if (phy[1] !== 6'd34) begin n_err++; $display("FAIL same_lane1: got %0d want 34", phy[1]); end
      drive(2'b00, 2'b11, 2'b00, 6'd1, 6'd2, 1'b0);
      step();
      drive(2'b00, 2'b00, 2'b11, 6'd3, 6'd4, 1'b0);
      step();
      drive(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
      step();
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      n_cmp++; if (fcnt !== 6'd32) begin n_err++; $display("FAIL nodst_count: got %0d want 32", fcnt); end
      n_cmp++; if (phy[0] !== 6'd33) begin n_err++; $display("FAIL nodst_lane0: got %0d want 33", phy[0]); end
      idle();
   endtask

   task automatic test_random(input int ncyc);
      logic [1:0] r, v, h;
      logic       w;
      int         avail, p;
      bit         exp_ready;
      for (int i = 0; i < ncyc; i++) begin
         if (((i / 40) % 2) == 0) begin
            r = 2'($urandom_range(1, 3));
            v = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         end else begin
            r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v = 2'($urandom_range(0, 3));
         end
         h = 2'($urandom_range(0, 3));
         w = ($urandom_range(0, 15) == 0);
         avail = spec_q.size();
         for (int j = 0; j < 2; j++)
            if (v[j] && h[j]) begin
               if (avail > 0) avail--;
               else h[j] = 1'b0;
            end
         drive(r, v, h, 6'($urandom), 6'($urandom), w);
         exp_ready = (free_q.size() >= 2) && !w;
         n_cmp++; if (fcnt !== 6'(free_q.size())) begin n_err++; $display("FAIL rand_count i%0d: got %0d want %0d", i, fcnt, free_q.size()); end
         n_cmp++; if (ready !== exp_ready) begin n_err++; $display("FAIL rand_ready i%0d: got %b want %b", i, ready, exp_ready); end
         p = 0;
         for (int k = 0; k < 2; k++)
            if (r[k]) begin
               if (p < free_q.size()) begin
                  n_cmp++;
                  if (phy[k] !== 6'(free_q[p])) begin
                     n_err++; $display("FAIL rand_lane%0d i%0d: got %0d want %0d", k, i, phy[k], free_q[p]);
                  end
               end
               p++;
            end
         step();
      end
      idle();
   endtask

   task automatic test_reset_mid();
      test_random(30);
      reset = 1'b1;
      drive(2'b11, 2'b11, 2'b11, 6'd3, 6'd4, 1'b1);
      step();
      reset = 1'b0;
      drive(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      n_cmp++; if (fcnt !== 6'd32) begin n_err++; $display("FAIL midreset_count: got %0d want 32", fcnt); end
      n_cmp++; if (phy[0] !== 6'd32) begin n_err++; $display("FAIL midreset_lane0: got %0d want 32", phy[0]); end
      n_cmp++; if (phy[1] !== 6'd33) begin n_err++; $display("FAIL midreset_lane1: got %0d want 33", phy[1]); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b want 1", ready); end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_fill_drain();
      test_partial();
      test_retire_refill();
      test_rewind();
      test_same_cycle();
      do_reset();
      test_random(800);
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
